// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int n, input int w);
    return n / w;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n, input int w);
    int c;
    c = n / w;
    return (c <= 1) ? 1 : $clog2(c);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_slice.sv
// Combinational N-bit adder with carry in/out, used as the per-chunk slice.
module chunked_serial_adder_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry_in,
  output logic [N-1:0] o_s,
  output logic         o_carry_out
);

  always_comb begin
    {o_carry_out, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_carry_in};
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle N-bit adder/subtractor that processes W bits per clock.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry_in,
  input  logic         i_sub,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_s,
  output logic         o_carry_out,
  output logic         o_overflow
);

  localparam int C  = num_chunks(N, W);
  localparam int IW = idx_width(N, W);
  localparam logic [IW-1:0] LAST = IW'(C - 1);

  if ((N % W) != 0) begin : g_bad_width
    $error("chunked_serial_adder: N must be a multiple of W");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    a_chunk, b_chunk, sum_chunk;
  logic            carry_chunk;
  logic            accept;

  assign a_chunk = a_q[idx_q*W +: W];
  assign b_chunk = b_q[idx_q*W +: W];
  assign accept  = i_start && (state_q != RUN);

  chunked_serial_adder_slice #(.N(W)) u_slice (
    .i_a         (a_chunk),
    .i_b         (b_chunk),
    .i_carry_in  (carry_q),
    .o_s         (sum_chunk),
    .o_carry_out (carry_chunk)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    state_d = i_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is folded into the operands at capture: B is inverted and
  // the carry-in toggled, so RUN only ever adds.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == RUN) begin
      s_d[idx_q*W +: W] = sum_chunk;
      carry_d           = carry_chunk;
      if (idx_q == LAST) begin
        idx_d  = '0;
        cout_d = carry_chunk;
        ovf_d  = (a_q[N-1] == b_q[N-1]) && (sum_chunk[W-1] != a_q[N-1]);
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (accept) begin
      a_d     = i_a;
      b_d     = i_sub ? ~i_b : i_b;
      carry_d = i_carry_in ^ i_sub;
      idx_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    o_busy      = (state_q == RUN);
    o_done      = (state_q == DONE);
    o_s         = s_q;
    o_carry_out = cout_q;
    o_overflow  = ovf_q;
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle N-bit adder/subtractor that processes W bits per clock, trading latency for area on wide datapaths.
- Generalises the team's combinational N-bit adder:
  - adds a start/done handshake and a subtract mode;
  - adds carry-out and signed-overflow reporting;
  - makes the chunk width a parameter.
- Sits in the ALU/arithmetic datapath, driven by a controller that issues one operation at a time.

Parameters:
- N, 64, operand/result width in bits.
- W, 16, bits processed per cycle. N must be a multiple of W; elaboration error otherwise. W = N gives a 1-cycle adder.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  request; sampled on rising edge; accepted only in IDLE or DONE.
- i_a  in  N  operand A; captured on accepted start.
- i_b  in  N  operand B; captured on accepted start.
- i_carry_in  in  1  carry in (borrow-in when i_sub=1); captured on accepted start.
- i_sub  in  1  0 = add, 1 = subtract; captured on accepted start.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse when result becomes valid.
- o_s  out  N  result; valid from o_done until the next accepted start.
- o_carry_out  out  1  carry out of the MSB (raw adder carry, not inverted for subtract).
- o_overflow  out  1  two's-complement signed overflow.

Behaviour:
- One clock; reset is asynchronous and active-high. Reset asserted at any time, including mid-operation:
  - state = IDLE, chunk index = 0;
  - o_busy, o_done, o_s, o_carry_out, o_overflow = 0;
  - operand and carry registers cleared.
- Constant C = N/W. Effective operands are B' = i_sub ? ~i_b : i_b and cin' = i_carry_in ^ i_sub:
  - sub with carry_in=0 computes A-B;
  - sub with carry_in=1 computes A-B-1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: i_start=1 → latch A, B', cin' into carry reg, index=0, next RUN.
  - RUN:
    - each edge adds chunk[index] of A and B' plus the carry reg;
    - writes the W-bit sum into result bits [index*W +: W];
    - updates the carry reg and increments the index;
    - after chunk C-1, next DONE. i_start is ignored in RUN.
  - DONE:
    - o_done=1 for exactly this cycle; o_s, o_carry_out and o_overflow are valid;
    - i_start=1 → accepted (back-to-back), next RUN, same latch actions as IDLE;
    - else next IDLE.
- Latency: start accepted at edge t → o_done high in the cycle following edge t+C. o_busy is high between edges t+1 and t+C.
- o_s, o_carry_out and o_overflow are registered.
  - They hold their value through IDLE and RUN until updated.
  - Intermediate chunks may be visible on o_s during RUN; o_s is defined only while o_done=1 and afterwards.
- o_carry_out = carry out of chunk C-1.
- o_overflow = (A[N-1] == B'[N-1]) && (S[N-1] != A[N-1]).
- Operand changes on the inputs after the start edge have no effect.

Decomposition:
- Package chunked_adder_pkg:
  - state enum typedef (IDLE, RUN, DONE);
  - function computing C and index width ($clog2(C), minimum 1).
- Sub-module: reuse the team's combinational adder module with N=W as the per-chunk slice (i_a, i_b, i_carry_in → o_s, o_carry_out).
- The FSM, operand registers and result assembly live in the top.

Test Plan:
All scenarios use N=64, W=16, so C=4.
- Reset mid-RUN:
  - stimulus: start A=5, B=7, then assert i_reset after 2 cycles;
  - required: all outputs 0 immediately (asynchronous); state IDLE; no o_done pulse afterwards.
- Basic add:
  - stimulus: A=1, B=0, cin=0, sub=0;
  - required: o_done pulses exactly 4 cycles after the start edge; o_s=1, carry=0, ovf=0; o_busy high for 4 cycles.
- Full carry ripple:
  - stimulus: A=2^64-1, B=0, cin=1;
  - required: o_s=0, o_carry_out=1, o_overflow=0.
  - stimulus: A=2^64-1, B=2^64-1, cin=1;
  - required: o_s=2^64-1, o_carry_out=1.
- Subtract and signed overflow:
  - stimulus: A=10, B=3, sub=1;
  - required: o_s=7, o_carry_out=1.
  - stimulus: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0;
  - required: o_s=0x8000_0000_0000_0000, o_overflow=1.
  - stimulus: A=0, B=1, sub=1;
  - required: o_s=2^64-1, o_carry_out=0, o_overflow=0.
- Start in RUN ignored and back-to-back:
  - stimulus: start 3+4, pulse i_start with 9+9 during RUN;
  - required: result 7, and no second done unless restarted.
  - stimulus: assert start in the DONE cycle with 9+9;
  - required: next o_done exactly 4 cycles later with o_s=18.
- Parameter edge W=N=64:
  - stimulus: A=2, B=3;
  - required: o_done in the cycle after the first RUN edge, o_s=5.
